// File: rtl/hash_w.sv
// hash_w - SHA-2 message-schedule stage.
// Loads one 16-word message block, then presents schedule word W_t on w for
// every round advance, generating W_16 onward in a 16-entry rolling window.
// Supports SHA-256 (32-bit words in [63:32]) and SHA-384/512 (64-bit words).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   h_clr      control-unit clear, aborts any load or run
//   h_flg_384  1 = SHA-384/512 mode, 0 = SHA-256 mode (latched per block)
//   m_vld      message word valid
//   m_word     message word (SHA-256 uses [63:32])
//   m_rdy      block can accept a message word
//   w_adv      advance to next round (from KW kw_nxt)
//   w          current schedule word W_t
//   w_full     16 words loaded, schedule valid
//   w_cnt      current round t
//   w_err      sticky: w_adv seen while not running
//
// state | meaning
// IDLE  | waiting for first word of a block, m_rdy = 1
// LOAD  | 1..15 words received, m_rdy = 1
// RUN   | schedule valid, advancing on w_adv
module hash_w (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_clr,
  input  logic        h_flg_384,
  input  logic        m_vld,
  input  logic [63:0] m_word,
  output logic        m_rdy,
  input  logic        w_adv,
  output logic [63:0] w,
  output logic        w_full,
  output logic [6:0]  w_cnt,
  output logic        w_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t      state;
  logic [3:0]  ld_cnt;
  logic        mode_q;
  logic [63:0] win [16];

  logic        ld_fire;
  logic        ld_mode;
  logic        last_adv;
  logic [63:0] ld_word;
  logic [63:0] w_new;

  function automatic logic [31:0] s0_256(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1_256(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] s0_512(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1_512(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  always_comb begin
    ld_fire  = m_vld && m_rdy;
    // The first word of a block is stored before mode_q has captured the mode.
    ld_mode  = (state == IDLE) ? h_flg_384 : mode_q;
    ld_word  = ld_mode ? m_word : {m_word[63:32], 32'h0};
    last_adv = mode_q ? (w_cnt == 7'd79) : (w_cnt == 7'd63);
    if (mode_q)
      w_new = s1_512(win[14]) + win[9] + s0_512(win[1]) + win[0];
    else
      w_new = {s1_256(win[14][63:32]) + win[9][63:32] +
               s0_256(win[1][63:32]) + win[0][63:32], 32'h0};
  end

  assign w = mode_q ? win[0] : {win[0][63:32], 32'h0};

  always_ff @(posedge clk) begin
    if (rst || h_clr) begin
      state  <= IDLE;
      ld_cnt <= '0;
      mode_q <= 1'b0;
      m_rdy  <= 1'b1;
      w_full <= 1'b0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      if (w_adv && (state != RUN)) w_err <= 1'b1;
      case (state)
        IDLE, LOAD: begin
          if (ld_fire) begin
            win[ld_cnt] <= ld_word;
            ld_cnt      <= ld_cnt + 4'd1;
            if (state == IDLE) begin
              mode_q <= h_flg_384;
              state  <= LOAD;
            end
            if (ld_cnt == 4'd15) begin
              state  <= RUN;
              m_rdy  <= 1'b0;
              w_full <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_adv) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_new;
            if (last_adv) begin
              state  <= IDLE;
              ld_cnt <= '0;
              w_cnt  <= '0;
              m_rdy  <= 1'b1;
              w_full <= 1'b0;
            end else begin
              w_cnt <= w_cnt + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_w.sv
// tb_hash_w - self-checking bench for hash_w.
// Expected schedule words come from the textbook SHA-2 recurrence over a
// full 80-entry array; results are compared cycle by cycle against the DUT.
module tb_hash_w;

  logic        clk = 1'b0;
  logic        rst, h_clr, h_flg_384, m_vld, w_adv;
  logic [63:0] m_word;
  logic        m_rdy, w_full, w_err;
  logic [63:0] w;
  logic [6:0]  w_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] blk   [16];
  logic [63:0] exp_w [80];

  hash_w dut (
    .clk(clk), .rst(rst), .h_clr(h_clr), .h_flg_384(h_flg_384),
    .m_vld(m_vld), .m_word(m_word), .m_rdy(m_rdy), .w_adv(w_adv),
    .w(w), .w_full(w_full), .w_cnt(w_cnt), .w_err(w_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Full-array SHA-2 message expansion from blk[] into exp_w[].
  task automatic gen_exp(input bit m512);
    logic [63:0] ws [80];
    logic [31:0] a, b;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        ws[t] = m512 ? blk[t] : {32'h0, blk[t][63:32]};
      end else if (m512) begin
        ws[t] = (r64(ws[t-2], 19) ^ r64(ws[t-2], 61) ^ (ws[t-2] >> 6)) + ws[t-7] +
                (r64(ws[t-15], 1) ^ r64(ws[t-15], 8) ^ (ws[t-15] >> 7)) + ws[t-16];
      end else begin
        a = ws[t-2][31:0];
        b = ws[t-15][31:0];
        ws[t] = {32'h0, (r32(a, 17) ^ r32(a, 19) ^ (a >> 10)) + ws[t-7][31:0] +
                        (r32(b, 7) ^ r32(b, 18) ^ (b >> 3)) + ws[t-16][31:0]};
      end
      exp_w[t] = m512 ? ws[t] : {ws[t][31:0], 32'h0};
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_m_rdy"},  64'(m_rdy),  64'd1);
    check({tag, "_w"},      w,           64'd0);
    check({tag, "_w_full"}, 64'(w_full), 64'd0);
    check({tag, "_w_cnt"},  64'(w_cnt),  64'd0);
    check({tag, "_w_err"},  64'(w_err),  64'd0);
  endtask

  // Loads n words of blk[]; switch_at >= 0 flips h_flg_384 to 1 from that word on.
  task automatic load_words(input int n, input bit mode, input bit gaps, input int switch_at);
    int got = 0;
    int budget = 0;
    while (got < n && budget < 400) begin
      m_vld     = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      m_word    = m_vld ? blk[got] : {$urandom, $urandom};
      h_flg_384 = (switch_at >= 0 && got >= switch_at) ? 1'b1 : mode;
      check("load_m_rdy", 64'(m_rdy), 64'd1);
      step();
      if (m_vld) got++;
      budget++;
    end
    if (got < n) check("load_budget", 64'(got), 64'(n));
    m_vld = 1'b0;
  endtask

  task automatic check_loaded();
    check("full_w_full", 64'(w_full), 64'd1);
    check("full_m_rdy",  64'(m_rdy),  64'd0);
    check("full_w0",     w,           exp_w[0]);
  endtask

  // Advances through the schedule until t == stop; end checks if stop == rounds.
  task automatic run_block(input int rounds, input int stop, input bit gaps);
    int t = 0;
    int budget = 0;
    while (t < stop && budget < 2000) begin
      w_adv  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      // Words offered while running must be ignored.
      m_vld  = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      m_word = {$urandom, $urandom};
      check($sformatf("w_t%0d", t), w, exp_w[t]);
      check("run_w_cnt",  64'(w_cnt),  64'(t));
      check("run_w_full", 64'(w_full), 64'd1);
      if (t == 16) check("w16_t16", w, exp_w[16]);
      step();
      if (w_adv) t++;
      budget++;
    end
    w_adv = 1'b0;
    m_vld = 1'b0;
    if (t < stop) check("run_budget", 64'(t), 64'(stop));
    if (stop == rounds) begin
      check("end_w_full", 64'(w_full), 64'd0);
      check("end_m_rdy",  64'(m_rdy),  64'd1);
      check("end_w_cnt",  64'(w_cnt),  64'd0);
      check("end_w_err",  64'(w_err),  64'd0);
    end
  endtask

  task automatic rand_blk();
    for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1; h_clr = 1'b0; h_flg_384 = 1'b0; m_vld = 1'b0; w_adv = 1'b0;
    m_word = '0;
    step(); step();
    rst = 1'b0;
    check_reset_vals("reset");

    // SHA-256 "abc"
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 64'h61626380_00000000;
    blk[15] = 64'h00000018_00000000;
    gen_exp(1'b0);
    check("abc256_model_w16", exp_w[16], 64'h61626380_00000000);
    check("abc256_model_w17", exp_w[17], 64'h000F0000_00000000);
    load_words(16, 1'b0, 1'b0, -1);
    check_loaded();
    run_block(64, 64, 1'b0);

    // SHA-512 "abc"
    blk[15] = 64'h18;
    gen_exp(1'b1);
    check("abc512_model_w16", exp_w[16], 64'h61626380_00000000);
    check("abc512_model_w17", exp_w[17], 64'h00030000_000000C0);
    load_words(16, 1'b1, 1'b0, -1);
    check_loaded();
    run_block(80, 80, 1'b0);

    // Random blocks with valid back-pressure and advance gaps
    for (int k = 0; k < 4; k++) begin
      bit m = k[0];
      rand_blk();
      gen_exp(m);
      load_words(16, m, 1'b1, -1);
      check_loaded();
      run_block(m ? 80 : 64, m ? 80 : 64, 1'b1);
    end

    // Mode latch: mode flips to 384 mid-load and stays there during the run
    rand_blk();
    gen_exp(1'b0);
    load_words(16, 1'b0, 1'b1, 8);
    check_loaded();
    run_block(64, 64, 1'b1);
    h_flg_384 = 1'b0;

    // Clear at t = 30 with w_adv high in the same cycle
    rand_blk();
    gen_exp(1'b1);
    load_words(16, 1'b1, 1'b0, -1);
    check_loaded();
    run_block(80, 30, 1'b0);
    check("pre_clr_w_cnt", 64'(w_cnt), 64'd30);
    w_adv = 1'b1; h_clr = 1'b1;
    step();
    w_adv = 1'b0; h_clr = 1'b0;
    check("clr_w_cnt",  64'(w_cnt),  64'd0);
    check("clr_m_rdy",  64'(m_rdy),  64'd1);
    check("clr_w_full", 64'(w_full), 64'd0);
    check("clr_w",      w,           64'd0);
    check("clr_w_err",  64'(w_err),  64'd0);

    // w_adv while idle: error is sticky until h_clr
    w_adv = 1'b1;
    step();
    w_adv = 1'b0;
    check("err_set",   64'(w_err), 64'd1);
    check("err_w_cnt", 64'(w_cnt), 64'd0);
    step(); step(); step();
    check("err_hold",  64'(w_err), 64'd1);
    check("err_m_rdy", 64'(m_rdy), 64'd1);
    h_clr = 1'b1;
    step();
    h_clr = 1'b0;
    check("err_clr", 64'(w_err), 64'd0);

    // Reset after 7 words, then a fresh load must work
    rand_blk();
    load_words(7, 1'b1, 1'b0, -1);
    check("mid_w_full", 64'(w_full), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("midload_rst");
    rand_blk();
    gen_exp(1'b0);
    load_words(16, 1'b0, 1'b0, -1);
    check_loaded();
    run_block(64, 64, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hash_w.md
# hash_w

Message-schedule stage of the SHA-2 hash core, directly upstream of the KW adder stage. It accepts one 16-word message block, then presents the current schedule word W_t on `w` for every round the round counter advances. Internal words W_16 onward are generated on the fly in a 16-entry rolling window. It supports SHA-256 (32-bit words carried in bits [63:32]) and SHA-384/512 (64-bit words).

## Interface
Parameters: none (the word count of 16 and the round counts of 64/80 are fixed by the standard).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `h_clr`  in  1  control-unit clear; aborts any load or run
- `h_flg_384`  in  1  1 = SHA-384/512 64-bit mode, 0 = SHA-256 32-bit mode
- `m_vld`  in  1  message word valid
- `m_word`  in  64  message word; in SHA-256 mode only [63:32] is used
- `m_rdy`  out  1  block can accept a message word
- `w_adv`  in  1  advance to the next round; driven by KW `kw_nxt`
- `w`  out  64  current schedule word W_t; SHA-256 mode gives {W_t, 32'd0}
- `w_full`  out  1  16 words loaded; schedule is valid
- `w_cnt`  out  7  current t (0..79)
- `w_err`  out  1  sticky: `w_adv` seen while `w_full` = 0

## Operation
- Storage: a 16×64 window `win[0..15]`. `w` = `win[0]`, formatted by mode.
- Mode latch: `mode_q` captures `h_flg_384` on the first accepted word of a block. Everything until the block finishes uses `mode_q`.
- States:
  - IDLE: `m_rdy` = 1, cnt = 0.
  - LOAD: 1..15 words received, `m_rdy` = 1.
  - RUN: `w_full` = 1, `m_rdy` = 0.
- Transitions:
  - IDLE→LOAD on the first handshake.
  - LOAD→RUN when the 16th word is accepted.
  - RUN→IDLE when the last advance completes: t = 63 with `w_adv` in 256 mode, t = 79 with `w_adv` in 384 mode.
- Load: when `m_vld && m_rdy`, `win[cnt] <= m_word`. In 256 mode bits [31:0] are stored as 0. cnt then increments.
- Advance (RUN with `w_adv`):
  - `win[i] <= win[i+1]` for i = 0..14.
  - `win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0]`.
  - `w_cnt` increments.
- 256 arithmetic, on bits [63:32], mod 2^32, low half forced to 0:
  - σ0 = ROTR7 ^ ROTR18 ^ SHR3
  - σ1 = ROTR17 ^ ROTR19 ^ SHR10
- 512 arithmetic, mod 2^64:
  - σ0 = ROTR1 ^ ROTR8 ^ SHR7
  - σ1 = ROTR19 ^ ROTR61 ^ SHR6
- Priority: `rst` > `h_clr` > load/advance.
- `rst` or `h_clr`:
  - State goes to IDLE; cnt, `w_cnt` and `win` go to 0.
  - `w_err` goes to 0 and `mode_q` goes to 0.
  - This applies in any state, including mid-load and mid-run.
- `w_adv` outside RUN: ignored (no shift, no count), and `w_err` is set to 1. `w_err` stays set until `rst` or `h_clr`.
- `m_vld` while `m_rdy` = 0: ignored. The word is not consumed and no error is raised.
- A new block can only load after RUN→IDLE. There is no prefetch.

## Timing
- Reset values of all outputs:
  - `m_rdy` = 1
  - `w` = 0
  - `w_full` = 0
  - `w_cnt` = 0
  - `w_err` = 0
- `m_rdy`, `w_full`, `w_cnt` and `w_err` are registered. `w` is combinational from `win[0]` and `mode_q`; it uses no other inputs.
- Load latency:
  - With `m_vld` held high, the 16 words take 16 cycles.
  - `w_full` = 1 and `m_rdy` = 0 in the cycle after the 16th handshake.
  - `w` = W_0 in that same cycle.
- Schedule timing: in the cycle where `w_adv` = 1 with `w_cnt` = t, `w` = W_t. KW registers k+w in that cycle.
- W_{t+1} appears the cycle after the advance, so consecutive `w_adv` cycles give one word per cycle with no bubbles.
- End of block:
  - After the final advance, `w_full` = 0, `m_rdy` = 1 and `w_cnt` = 0 in the next cycle.
  - `w` is then the rolled window value and is don't-care.
- Gaps in `w_adv` stall the schedule. `w` holds its value.
- `h_clr` takes effect in the cycle after it is sampled, even if `w_adv` is high in the same cycle.

## Test plan
- SHA-256 "abc":
  - Stimulus: load W0 = 0x61626380_00000000, W1–W14 = 0, W15 = 0x00000018_00000000, `h_flg_384` = 0; then 64 × `w_adv`.
  - Required: `w` at t = 16 is 0x61626380_00000000; at t = 17 it is 0x000F0000_00000000.
  - Required: `w_full` falls after exactly 64 advances.
- SHA-512 "abc":
  - Stimulus: W0 = 0x61626380_00000000, W15 = 0x18, others 0, `h_flg_384` = 1; then 80 × `w_adv`.
  - Required: t = 16 gives 0x61626380_00000000; t = 17 gives 0x00030000_000000C0.
  - Required: RUN→IDLE after 80 advances.
- Back-pressure and stall:
  - Stimulus: toggle `m_vld` randomly during load.
  - Required: exactly 16 words are captured, in order.
  - Stimulus: insert `w_adv` gaps during run.
  - Required: the `w` sequence matches the gap-free run, with `w` held during gaps.
- Mode latch: set `h_flg_384` = 0 at the first word, switch it to 1 mid-block; the block must stay in 256 behaviour with 64 rounds and the low half zero.
- Clear and error:
  - Stimulus: `h_clr` at t = 30 during run.
  - Required: next cycle `w_cnt` = 0, `m_rdy` = 1, `w_full` = 0.
  - Stimulus: `w_adv` while IDLE.
  - Required: `w_err` = 1, `w_cnt` stays 0; `w_err` stays 1 until the next `h_clr`.
- Reset mid-load: assert `rst` after 7 words; next cycle all outputs equal their reset values, and a fresh 16-word load then works.
